// File: rtl/cprv_decode_stage.sv
// Decode stage of the CPRV pipeline: decodes the fetched instruction, reads operands and
// stalls one cycle on load-use. Optional write-back bypass: CPRV_DECODE_WB_BYPASS_EN.
module cprv_decode_stage #(
  parameter int XLEN        = 64,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_id_i,
  output logic                   ready_id_o,
  input  logic [INSTR_WIDTH-1:0] instr_data_id_i,
  input  logic [XLEN-1:0]        pc_id_i,
  input  logic                   flush_i,
  output logic [4:0]             rs1_addr_rf_o,
  output logic [4:0]             rs2_addr_rf_o,
  input  logic [XLEN-1:0]        rs1_data_rf_i,
  input  logic [XLEN-1:0]        rs2_data_rf_i,
  input  logic                   wb_en_i,
  input  logic [4:0]             wb_addr_i,
  input  logic [XLEN-1:0]        wb_data_i,
  output logic                   valid_ex_o,
  input  logic                   ready_ex_i,
  output logic [XLEN-1:0]        rs1_data_ex_o,
  output logic [XLEN-1:0]        rs2_data_ex_o,
  output logic [XLEN-1:0]        imm_data_ex_o,
  output logic [XLEN-1:0]        pc_ex_o,
  output logic [4:0]             rd_addr_ex_o,
  output logic                   rd_en_ex_o,
  output logic                   mem_r_en_ex_o,
  output logic                   mem_w_en_ex_o,
  output logic                   illegal_ex_o,
  output logic [6:0]             opcode_ex_o,
  output logic [2:0]             funct3_ex_o,
  output logic [6:0]             funct7_ex_o
);

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;

  logic [31:0]     ins;
  logic [6:0]      opcode;
  logic [4:0]      rd_addr;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;

  assign ins      = instr_data_id_i[31:0];
  assign opcode   = ins[6:0];
  assign rd_addr  = ins[11:7];
  assign rs1_addr = ins[19:15];
  assign rs2_addr = ins[24:20];

  assign rs1_addr_rf_o = rs1_addr;
  assign rs2_addr_rf_o = rs2_addr;

  assign imm_i = XLEN'($signed(ins[31:20]));
  assign imm_s = XLEN'($signed({ins[31:25], ins[11:7]}));
  assign imm_b = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({ins[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));

  logic            dec_legal;
  logic            dec_rd_en;
  logic            dec_mem_r;
  logic            dec_mem_w;
  logic            dec_illegal;
  logic [XLEN-1:0] dec_imm;

  always_comb begin
    dec_legal = 1'b0;
    dec_rd_en = 1'b0;
    dec_mem_r = 1'b0;
    dec_mem_w = 1'b0;
    dec_imm   = '0;
    case (opcode)
      OPC_OP: begin
        dec_legal = 1'b1;
        dec_rd_en = 1'b1;
      end
      OPC_OP_IMM: begin
        dec_legal = 1'b1;
        dec_rd_en = 1'b1;
        dec_imm   = imm_i;
      end
      // Word-sized ops only exist on RV64.
      OPC_OP_32: begin
        dec_legal = (XLEN != 32);
        dec_rd_en = 1'b1;
      end
      OPC_OP_IMM_32: begin
        dec_legal = (XLEN != 32);
        dec_rd_en = 1'b1;
        dec_imm   = imm_i;
      end
      OPC_LOAD: begin
        dec_legal = 1'b1;
        dec_rd_en = 1'b1;
        dec_mem_r = 1'b1;
        dec_imm   = imm_i;
      end
      OPC_LUI, OPC_AUIPC: begin
        dec_legal = 1'b1;
        dec_rd_en = 1'b1;
        dec_imm   = imm_u;
      end
      OPC_JAL: begin
        dec_legal = 1'b1;
        dec_rd_en = 1'b1;
        dec_imm   = imm_j;
      end
      OPC_JALR: begin
        dec_legal = 1'b1;
        dec_rd_en = 1'b1;
        dec_imm   = imm_i;
      end
      OPC_STORE: begin
        dec_legal = 1'b1;
        dec_mem_w = 1'b1;
        dec_imm   = imm_s;
      end
      OPC_BRANCH: begin
        dec_legal = 1'b1;
        dec_imm   = imm_b;
      end
      default: begin
        dec_legal = 1'b0;
      end
    endcase
    if (rd_addr == 5'd0) dec_rd_en = 1'b0;
    dec_illegal = ~dec_legal | (ins[1:0] != 2'b11);
  end

  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;

`ifdef CPRV_DECODE_WB_BYPASS_EN
  // A write-back landing this cycle is newer than what the register file returns.
  always_comb begin
    rs1_val = rs1_data_rf_i;
    rs2_val = rs2_data_rf_i;
    if (wb_en_i && (wb_addr_i == rs1_addr)) rs1_val = wb_data_i;
    if (wb_en_i && (wb_addr_i == rs2_addr)) rs2_val = wb_data_i;
    if (rs1_addr == 5'd0) rs1_val = '0;
    if (rs2_addr == 5'd0) rs2_val = '0;
  end
`else
  logic unused_wb;
  assign unused_wb = ^{wb_en_i, wb_addr_i, wb_data_i};

  always_comb begin
    rs1_val = (rs1_addr == 5'd0) ? '0 : rs1_data_rf_i;
    rs2_val = (rs2_addr == 5'd0) ? '0 : rs2_data_rf_i;
  end
`endif

  logic cke;
  logic hazard;
  logic accept;

  // A load in EX cannot forward its data yet, so a dependent instruction waits one cycle.
  assign hazard = valid_ex_o & mem_r_en_ex_o & rd_en_ex_o & valid_id_i &
                  ((rd_addr_ex_o == rs1_addr) | (rd_addr_ex_o == rs2_addr));
  assign cke        = ~valid_ex_o | ready_ex_i;
  assign ready_id_o = cke & ~hazard;
  assign accept     = valid_id_i & ready_id_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_ex_o    <= 1'b0;
      rs1_data_ex_o <= '0;
      rs2_data_ex_o <= '0;
      imm_data_ex_o <= '0;
      pc_ex_o       <= '0;
      rd_addr_ex_o  <= '0;
      rd_en_ex_o    <= 1'b0;
      mem_r_en_ex_o <= 1'b0;
      mem_w_en_ex_o <= 1'b0;
      illegal_ex_o  <= 1'b0;
      opcode_ex_o   <= '0;
      funct3_ex_o   <= '0;
      funct7_ex_o   <= '0;
    end else if (flush_i) begin
      valid_ex_o <= 1'b0;
    end else if (cke) begin
      valid_ex_o <= accept;
      if (accept) begin
        rs1_data_ex_o <= rs1_val;
        rs2_data_ex_o <= rs2_val;
        imm_data_ex_o <= dec_imm;
        pc_ex_o       <= pc_id_i;
        rd_addr_ex_o  <= rd_addr;
        rd_en_ex_o    <= dec_rd_en;
        mem_r_en_ex_o <= dec_mem_r;
        mem_w_en_ex_o <= dec_mem_w;
        illegal_ex_o  <= dec_illegal;
        opcode_ex_o   <= opcode;
        funct3_ex_o   <= ins[14:12];
        funct7_ex_o   <= ins[31:25];
      end
    end
  end

endmodule

// File: tb/tb_cprv_decode_stage.sv
// Self-checking bench for cprv_decode_stage: directed scenarios followed by randomized
// traffic compared against a behavioural pipeline model.
module tb_cprv_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_id_i;
  logic        ready_id_o;
  logic [31:0] instr_data_id_i;
  logic [63:0] pc_id_i;
  logic        flush_i;
  logic [4:0]  rs1_addr_rf_o;
  logic [4:0]  rs2_addr_rf_o;
  logic [63:0] rs1_data_rf_i;
  logic [63:0] rs2_data_rf_i;
  logic        wb_en_i;
  logic [4:0]  wb_addr_i;
  logic [63:0] wb_data_i;
  logic        valid_ex_o;
  logic        ready_ex_i;
  logic [63:0] rs1_data_ex_o;
  logic [63:0] rs2_data_ex_o;
  logic [63:0] imm_data_ex_o;
  logic [63:0] pc_ex_o;
  logic [4:0]  rd_addr_ex_o;
  logic        rd_en_ex_o;
  logic        mem_r_en_ex_o;
  logic        mem_w_en_ex_o;
  logic        illegal_ex_o;
  logic [6:0]  opcode_ex_o;
  logic [2:0]  funct3_ex_o;
  logic [6:0]  funct7_ex_o;

  cprv_decode_stage dut (
    .clk(clk), .rst(rst),
    .valid_id_i(valid_id_i), .ready_id_o(ready_id_o),
    .instr_data_id_i(instr_data_id_i), .pc_id_i(pc_id_i), .flush_i(flush_i),
    .rs1_addr_rf_o(rs1_addr_rf_o), .rs2_addr_rf_o(rs2_addr_rf_o),
    .rs1_data_rf_i(rs1_data_rf_i), .rs2_data_rf_i(rs2_data_rf_i),
    .wb_en_i(wb_en_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
    .valid_ex_o(valid_ex_o), .ready_ex_i(ready_ex_i),
    .rs1_data_ex_o(rs1_data_ex_o), .rs2_data_ex_o(rs2_data_ex_o),
    .imm_data_ex_o(imm_data_ex_o), .pc_ex_o(pc_ex_o),
    .rd_addr_ex_o(rd_addr_ex_o), .rd_en_ex_o(rd_en_ex_o),
    .mem_r_en_ex_o(mem_r_en_ex_o), .mem_w_en_ex_o(mem_w_en_ex_o),
    .illegal_ex_o(illegal_ex_o), .opcode_ex_o(opcode_ex_o),
    .funct3_ex_o(funct3_ex_o), .funct7_ex_o(funct7_ex_o)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Behavioural view of what EX should hold.
  logic        m_valid;
  logic [63:0] m_rs1, m_rs2, m_imm, m_pc;
  logic [4:0]  m_rd;
  logic        m_rden, m_memr, m_memw, m_ill;
  logic [6:0]  m_op, m_f7;
  logic [2:0]  m_f3;

  logic [6:0] opTable [12] = '{7'b0110011, 7'b0010011, 7'b0111011, 7'b0011011,
                               7'b0000011, 7'b0110111, 7'b0010111, 7'b1101111,
                               7'b1100111, 7'b0100011, 7'b1100011, 7'b1110011};

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit isLegalOpcode(logic [6:0] op);
    for (int k = 0; k < 11; k++) if (opTable[k] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit writesRd(logic [6:0] op);
    return isLegalOpcode(op) && op != 7'b0100011 && op != 7'b1100011;
  endfunction

  // Immediates rebuilt from a sign-extended copy of the word with shifts and masks.
  function automatic logic [63:0] refImm(logic [31:0] w);
    longint s;
    s = longint'($signed(w));
    case (w[6:0])
      7'b0010011, 7'b0011011, 7'b0000011, 7'b1100111: return s >>> 20;
      7'b0100011: return ((s >>> 25) << 5) | longint'(w[11:7]);
      7'b1100011: return ((s >>> 31) << 12) | (longint'(w[7]) << 11) |
                         (longint'(w[30:25]) << 5) | (longint'(w[11:8]) << 1);
      7'b0110111, 7'b0010111: return (s >>> 12) << 12;
      7'b1101111: return ((s >>> 31) << 20) | (longint'(w[19:12]) << 12) |
                         (longint'(w[20]) << 11) | (longint'(w[30:21]) << 1);
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [63:0] refOperand(logic [4:0] a, logic [63:0] rf);
    if (a == 5'd0) return 64'd0;
`ifdef CPRV_DECODE_WB_BYPASS_EN
    if (wb_en_i && wb_addr_i == a) return wb_data_i;
`endif
    return rf;
  endfunction

  function automatic logic [31:0] randInstr();
    logic [31:0] w;
    w = $urandom;
    w[6:0] = opTable[$urandom_range(0, 11)];
    if ($urandom_range(0, 15) == 0) w[1:0] = 2'($urandom_range(0, 2));
    w[11:7]  = 5'($urandom_range(0, 3));
    w[19:15] = 5'($urandom_range(0, 3));
    w[24:20] = 5'($urandom_range(0, 3));
    return w;
  endfunction

  task automatic modelReset();
    m_valid = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0; m_pc = 0; m_rd = 0;
    m_rden = 0; m_memr = 0; m_memw = 0; m_ill = 0; m_op = 0; m_f3 = 0; m_f7 = 0;
  endtask

  task automatic checkState();
    checkOutput("valid_ex", 64'(valid_ex_o), 64'(m_valid));
    if (m_valid) begin
      checkOutput("rs1_data", rs1_data_ex_o, m_rs1);
      checkOutput("rs2_data", rs2_data_ex_o, m_rs2);
      checkOutput("imm", imm_data_ex_o, m_imm);
      checkOutput("pc", pc_ex_o, m_pc);
      checkOutput("rd_addr", 64'(rd_addr_ex_o), 64'(m_rd));
      checkOutput("rd_en", 64'(rd_en_ex_o), 64'(m_rden));
      checkOutput("mem_r", 64'(mem_r_en_ex_o), 64'(m_memr));
      checkOutput("mem_w", 64'(mem_w_en_ex_o), 64'(m_memw));
      checkOutput("illegal", 64'(illegal_ex_o), 64'(m_ill));
      checkOutput("fields", {43'd0, opcode_ex_o, funct3_ex_o, funct7_ex_o},
                  {43'd0, m_op, m_f3, m_f7});
    end
  endtask

  // One cycle: drive at the falling edge, check handshake, advance model, check EX after the edge.
  task automatic applyStimulus(input logic v, input logic [31:0] w, input logic [63:0] pc,
                               input logic [63:0] rf1, input logic [63:0] rf2,
                               input logic rdy, input logic fl);
    bit cke, haz, rdy_exp;
    @(negedge clk);
    valid_id_i = v; instr_data_id_i = w; pc_id_i = pc;
    rs1_data_rf_i = rf1; rs2_data_rf_i = rf2; ready_ex_i = rdy; flush_i = fl;
    #1;
    cke     = !m_valid || rdy;
    haz     = m_valid && m_memr && m_rden && v && (m_rd == w[19:15] || m_rd == w[24:20]);
    rdy_exp = cke && !haz;
    checkOutput("ready_id", 64'(ready_id_o), 64'(rdy_exp));
    checkOutput("rs_addr", {54'd0, rs1_addr_rf_o, rs2_addr_rf_o}, {54'd0, w[19:15], w[24:20]});
    if (fl) m_valid = 0;
    else if (cke) begin
      m_valid = v && rdy_exp;
      if (m_valid) begin
        m_rs1 = refOperand(w[19:15], rf1);
        m_rs2 = refOperand(w[24:20], rf2);
        m_imm = refImm(w);
        m_pc = pc; m_rd = w[11:7];
        m_rden = writesRd(w[6:0]) && w[11:7] != 0;
        m_memr = (w[6:0] == 7'b0000011);
        m_memw = (w[6:0] == 7'b0100011);
        m_ill  = (w[1:0] != 2'b11) || !isLegalOpcode(w[6:0]);
        m_op = w[6:0]; m_f3 = w[14:12]; m_f7 = w[31:25];
      end
    end
    @(posedge clk);
    #1;
    checkState();
  endtask

  initial begin
    rst = 1; valid_id_i = 0; instr_data_id_i = 0; pc_id_i = 0; flush_i = 0;
    rs1_data_rf_i = 0; rs2_data_rf_i = 0; wb_en_i = 0; wb_addr_i = 0; wb_data_i = 0;
    ready_ex_i = 1;
    modelReset();
    #2;
    checkOutput("reset_valid", 64'(valid_ex_o), 64'd0);
    checkOutput("reset_imm", imm_data_ex_o, 64'd0);
    @(negedge clk);
    rst = 0;
    #1;
    checkOutput("ready_after_reset", 64'(ready_id_o), 64'd1);

    // ADDI x5,x0,-1 with junk on the rs1 read port
    applyStimulus(1, 32'hFFF00293, 64'h1000, 64'hDEAD, 64'hBEEF, 1, 0);
    checkOutput("addi_valid", 64'(valid_ex_o), 64'd1);
    checkOutput("addi_rd", 64'(rd_addr_ex_o), 64'd5);
    checkOutput("addi_rden", 64'(rd_en_ex_o), 64'd1);
    checkOutput("addi_imm", imm_data_ex_o, 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("addi_rs1", rs1_data_ex_o, 64'd0);

    // Backpressure for two cycles, then release
    applyStimulus(1, 32'h00208133, 64'h1004, 64'h11, 64'h22, 0, 0);
    checkOutput("bp_ready", 64'(ready_id_o), 64'd0);
    applyStimulus(1, 32'h00208133, 64'h1004, 64'h11, 64'h22, 0, 0);
    checkOutput("bp_hold_rd", 64'(rd_addr_ex_o), 64'd5);
    applyStimulus(1, 32'h00208133, 64'h1004, 64'h11, 64'h22, 1, 0);
    checkOutput("bp_resume_rd", 64'(rd_addr_ex_o), 64'd2);

    // Load-use: LD x6,0(x1) then ADD x7,x6,x2
    applyStimulus(1, 32'h0000B303, 64'h2000, 64'h100, 64'h0, 1, 0);
    applyStimulus(1, 32'h002303B3, 64'h2004, 64'h5, 64'h6, 1, 0);
    checkOutput("lu_bubble", 64'(valid_ex_o), 64'd0);
    applyStimulus(1, 32'h002303B3, 64'h2004, 64'h5, 64'h6, 1, 0);
    checkOutput("lu_add_rd", 64'(rd_addr_ex_o), 64'd7);

    // Flush with a valid EX and a presented instruction
    applyStimulus(1, 32'h00100513, 64'h3000, 64'h0, 64'h0, 1, 0);
    applyStimulus(1, 32'h00200593, 64'h3004, 64'h0, 64'h0, 1, 1);
    checkOutput("flush_valid", 64'(valid_ex_o), 64'd0);
    applyStimulus(0, 32'h00200593, 64'h3004, 64'h0, 64'h0, 1, 0);
    checkOutput("flush_dropped", 64'(valid_ex_o), 64'd0);

    // Write-back to x3 while decoding ADDI x1,x3,0
    wb_en_i = 1; wb_addr_i = 5'd3; wb_data_i = 64'h1234;
    applyStimulus(1, 32'h00018093, 64'h4000, 64'h0, 64'h0, 1, 0);
`ifdef CPRV_DECODE_WB_BYPASS_EN
    checkOutput("wb_bypass", rs1_data_ex_o, 64'h1234);
`else
    checkOutput("wb_no_bypass", rs1_data_ex_o, 64'h0);
`endif
    wb_en_i = 0;

    // Reset mid-stream takes effect without a clock edge
    applyStimulus(1, 32'hFFF00293, 64'h5000, 64'h0, 64'h0, 1, 0);
    #2;
    rst = 1;
    #1;
    checkOutput("midrst_valid", 64'(valid_ex_o), 64'd0);
    checkOutput("midrst_outs", {rd_addr_ex_o, rd_en_ex_o, opcode_ex_o} | imm_data_ex_o | pc_ex_o,
                64'd0);
    modelReset();
    @(negedge clk);
    rst = 0;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      wb_en_i   = 1'($urandom);
      wb_addr_i = 5'($urandom_range(0, 3));
      wb_data_i = {$urandom, $urandom};
      applyStimulus(1'($urandom_range(0, 3) != 0), randInstr(), {$urandom, $urandom},
                    {$urandom, $urandom}, {$urandom, $urandom},
                    1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
